// File: rtl/byte_unstriping.sv
// byte_unstriping: merges two skewed 32-bit lanes back into one stream.
// Output order is strictly lane 0, lane 1, lane 0, ... Each lane has a small
// FIFO to absorb inter-lane skew. Sticky flags report dropped words (overflow)
// and a lane that stays starved while the other lane holds data (skew_err).
module byte_unstriping #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 3
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] lane0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] lane1,
  input  logic              valid_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              overflow,
  output logic              skew_err
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int STALL_W = $clog2(SKEW_MAX + 1);

  typedef enum logic {
    READ_L0 = 1'b0,
    READ_L1 = 1'b1
  } sel_t;

  sel_t               sel_r;
  logic [STALL_W-1:0] stall_cnt_r;

  logic [DATA_W-1:0] mem0_r [DEPTH];
  logic [DATA_W-1:0] mem1_r [DEPTH];
  logic [PTR_W-1:0]  wr0_r, rd0_r, wr1_r, rd1_r;
  logic [CNT_W-1:0]  cnt0_r, cnt1_r;

  logic               empty0_s, empty1_s, full0_s, full1_s;
  logic               pop0_s, pop1_s, push0_s, push1_s, drop0_s, drop1_s;
  logic               stall_s;
  logic [STALL_W-1:0] stall_nxt_s;

  // Derive FIFO status, pop/push decisions and the next stall count.
  always_comb begin
    empty0_s = (cnt0_r == CNT_W'(0));
    empty1_s = (cnt1_r == CNT_W'(0));
    full0_s  = (cnt0_r == CNT_W'(DEPTH));
    full1_s  = (cnt1_r == CNT_W'(DEPTH));
    // Only the selected lane may be popped, so lanes never reorder.
    pop0_s   = (sel_r == READ_L0) && !empty0_s;
    pop1_s   = (sel_r == READ_L1) && !empty1_s;
    // A full FIFO still accepts a word when it is popped in the same cycle.
    push0_s  = valid_0 && (!full0_s || pop0_s);
    push1_s  = valid_1 && (!full1_s || pop1_s);
    drop0_s  = valid_0 && full0_s && !pop0_s;
    drop1_s  = valid_1 && full1_s && !pop1_s;
    // Stalled: selected lane starved while the other lane already has data.
    stall_s  = (sel_r == READ_L0) ? (empty0_s && !empty1_s) : (empty1_s && !empty0_s);
    if (pop0_s || pop1_s) begin
      stall_nxt_s = STALL_W'(0);
    end else if (stall_s && (stall_cnt_r != STALL_W'(SKEW_MAX))) begin
      stall_nxt_s = stall_cnt_r + STALL_W'(1);
    end else begin
      stall_nxt_s = stall_cnt_r;
    end
  end

  // Lane FIFO storage writes (contents need no reset; pointers gate them).
  always_ff @(posedge clk_2f) begin
    if (push0_s) begin
      mem0_r[wr0_r] <= lane0;
    end
    if (push1_s) begin
      mem1_r[wr1_r] <= lane1;
    end
  end

  // Lane 0 FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr0_r  <= PTR_W'(0);
      rd0_r  <= PTR_W'(0);
      cnt0_r <= CNT_W'(0);
    end else begin
      if (push0_s) begin
        wr0_r <= wr0_r + PTR_W'(1);
      end
      if (pop0_s) begin
        rd0_r <= rd0_r + PTR_W'(1);
      end
      case ({push0_s, pop0_s})
        2'b10:   cnt0_r <= cnt0_r + CNT_W'(1);
        2'b01:   cnt0_r <= cnt0_r - CNT_W'(1);
        default: cnt0_r <= cnt0_r;
      endcase
    end
  end

  // Lane 1 FIFO pointers and occupancy; pointers wrap modulo DEPTH.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr1_r  <= PTR_W'(0);
      rd1_r  <= PTR_W'(0);
      cnt1_r <= CNT_W'(0);
    end else begin
      if (push1_s) begin
        wr1_r <= wr1_r + PTR_W'(1);
      end
      if (pop1_s) begin
        rd1_r <= rd1_r + PTR_W'(1);
      end
      case ({push1_s, pop1_s})
        2'b10:   cnt1_r <= cnt1_r + CNT_W'(1);
        2'b01:   cnt1_r <= cnt1_r - CNT_W'(1);
        default: cnt1_r <= cnt1_r;
      endcase
    end
  end

  // Lane selector FSM with registered output word and sticky error flags.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel_r       <= READ_L0;
      stall_cnt_r <= STALL_W'(0);
      data_out    <= DATA_W'(0);
      valid_out   <= 1'b0;
      overflow    <= 1'b0;
      skew_err    <= 1'b0;
    end else begin
      case (sel_r)
        READ_L0: begin
          if (pop0_s) begin
            data_out  <= mem0_r[rd0_r];
            valid_out <= 1'b1;
            sel_r     <= READ_L1;
          end else begin
            valid_out <= 1'b0;
          end
        end
        READ_L1: begin
          if (pop1_s) begin
            data_out  <= mem1_r[rd1_r];
            valid_out <= 1'b1;
            sel_r     <= READ_L0;
          end else begin
            valid_out <= 1'b0;
          end
        end
        default: begin
          valid_out <= 1'b0;
          sel_r     <= READ_L0;
        end
      endcase
      stall_cnt_r <= stall_nxt_s;
      overflow    <= overflow | drop0_s | drop1_s;
      skew_err    <= skew_err | (stall_nxt_s == STALL_W'(SKEW_MAX));
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Testbench for byte_unstriping: directed scenarios with literal expectations
// plus randomized traffic checked against a queue-based reference model.
module tb_byte_unstriping;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 4;
  localparam int SKEW_MAX = 3;

  logic              clk_2f = 1'b0;
  logic              reset  = 1'b1;
  logic [DATA_W-1:0] lane0  = 32'h0;
  logic              valid_0 = 1'b0;
  logic [DATA_W-1:0] lane1  = 32'h0;
  logic              valid_1 = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              overflow;
  logic              skew_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: per-lane queues plus expected outputs.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          m_sel;
  int          m_stall;
  logic [31:0] m_data;
  logic        m_valid, m_ovf, m_skew;

  byte_unstriping #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SKEW_MAX(SKEW_MAX)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .lane0(lane0), .valid_0(valid_0),
    .lane1(lane1), .valid_1(valid_1),
    .data_out(data_out), .valid_out(valid_out),
    .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk_2f = ~clk_2f;

  // Advance the model by one clock edge with the inputs that edge sampled.
  task automatic model_step(input logic r, input logic v0, input logic [31:0] d0,
                            input logic v1, input logic [31:0] d1);
    bit popped;
    popped = 1'b0;
    if (r) begin
      q0.delete(); q1.delete();
      m_sel = 1'b0; m_stall = 0; m_data = 32'h0;
      m_valid = 1'b0; m_ovf = 1'b0; m_skew = 1'b0;
    end else begin
      if (!m_sel && q0.size() > 0) begin
        m_data = q0.pop_front(); popped = 1'b1;
      end else if (m_sel && q1.size() > 0) begin
        m_data = q1.pop_front(); popped = 1'b1;
      end
      if (popped) begin
        m_valid = 1'b1; m_sel = !m_sel; m_stall = 0;
      end else begin
        m_valid = 1'b0;
        if ((m_sel ? q0.size() : q1.size()) > 0) begin
          m_stall++;
          if (m_stall >= SKEW_MAX) m_skew = 1'b1;
        end
      end
      if (v0) begin
        if (q0.size() < DEPTH) q0.push_back(d0); else m_ovf = 1'b1;
      end
      if (v1) begin
        if (q1.size() < DEPTH) q1.push_back(d1); else m_ovf = 1'b1;
      end
    end
  endtask

  // Apply inputs for one cycle, clock them in, and sample 1 time unit later.
  task automatic drive(input logic r, input logic v0, input logic [31:0] d0,
                       input logic v1, input logic [31:0] d1);
    reset = r; valid_0 = v0; lane0 = d0; valid_1 = v1; lane1 = d1;
    @(posedge clk_2f);
    #1;
    model_step(r, v0, d0, v1, d1);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    total++; if (skew_err !== 1'b0) begin bad++; $display("FAIL reset_skew: got %b want 0", skew_err); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", valid_out); end
    end
  endtask

  task automatic test_nominal();
    logic [31:0] words [4];
    logic        exp_v;
    words = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC};
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (i == 0 || i == 2), words[i % 4], (i == 1 || i == 3), words[i % 4]);
      exp_v = (i >= 1 && i <= 4);
      total++; if (valid_out !== exp_v) begin bad++; $display("FAIL nominal_valid[%0d]: got %b want %b", i, valid_out, exp_v); end
      if (exp_v) begin
        total++; if (data_out !== words[(i + 3) % 4]) begin bad++; $display("FAIL nominal_data[%0d]: got %h want %h", i, data_out, words[(i + 3) % 4]); end
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL nominal_ovf: got %b want 0", overflow); end
    total++; if (skew_err !== 1'b0) begin bad++; $display("FAIL nominal_skew: got %b want 0", skew_err); end
  endtask

  task automatic test_simultaneous();
    int nvalid;
    logic exp_v;
    nvalid = 0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i == 0), 32'h00000003, (i == 0), 32'h00000004);
      exp_v = (i == 1 || i == 2);
      if (valid_out === 1'b1) nvalid++;
      total++; if (valid_out !== exp_v) begin bad++; $display("FAIL simul_valid[%0d]: got %b want %b", i, valid_out, exp_v); end
      if (exp_v) begin
        total++; if (data_out !== ((i == 1) ? 32'h3 : 32'h4)) begin bad++; $display("FAIL simul_data[%0d]: got %h want %h", i, data_out, (i == 1) ? 32'h3 : 32'h4); end
      end
    end
    total++; if (nvalid != 2) begin bad++; $display("FAIL simul_count: got %0d want 2", nvalid); end
  endtask

  task automatic test_lane1_first();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, (i < 3), 32'hAAAAAAAA);
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL l1first_wait[%0d]: got %b want 0", i, valid_out); end
    end
    total++; if (skew_err !== 1'b1) begin bad++; $display("FAIL l1first_skew: got %b want 1", skew_err); end
    drive(1'b0, 1'b1, 32'h99999999, 1'b0, 32'h0);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL l1first_lat: got %b want 0", valid_out); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (valid_out !== 1'b1 || data_out !== 32'h99999999) begin bad++; $display("FAIL l1first_w0: got %b/%h want 1/99999999", valid_out, data_out); end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (valid_out !== 1'b1 || data_out !== 32'hAAAAAAAA) begin bad++; $display("FAIL l1first_w1: got %b/%h want 1/aaaaaaaa", valid_out, data_out); end
    total++; if (skew_err !== 1'b1) begin bad++; $display("FAIL l1first_sticky: got %b want 1", skew_err); end
  endtask

  task automatic test_overflow();
    logic [31:0] got[$];
    logic [31:0] exp_seq [8];
    exp_seq = '{32'h1, 32'h5, 32'h2, 32'h6, 32'h3, 32'h7, 32'h4, 32'h8};
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h5 + 32'(i));
      if (i == 3) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, (i < 4), 32'h1 + 32'(i), 1'b0, 32'h0);
      if (valid_out === 1'b1) got.push_back(data_out);
    end
    total++; if (got.size() != 8) begin bad++; $display("FAIL ovf_count: got %0d want 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL ovf_seq[%0d]: got %h want %h", i, got[i], exp_seq[i]); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_midstream_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h11111111);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h22222222);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (valid_out !== 1'b0 || data_out !== 32'h0) begin bad++; $display("FAIL midrst_out: got %b/%h want 0/0", valid_out, data_out); end
    total++; if (overflow !== 1'b0 || skew_err !== 1'b0) begin bad++; $display("FAIL midrst_flags: got %b%b want 00", overflow, skew_err); end
    drive(1'b0, 1'b1, 32'hBBBBBBBB, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    total++; if (valid_out !== 1'b1 || data_out !== 32'hBBBBBBBB) begin bad++; $display("FAIL midrst_first: got %b/%h want 1/bbbbbbbb", valid_out, data_out); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d]: got %b/%h want 0", i, valid_out, data_out); end
    end
  endtask

  task automatic test_random();
    int p;
    logic v0, v1;
    for (int e = 0; e < 8; e++) begin
      p = 20 + e * 6;
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int c = 0; c < 60; c++) begin
        v0 = ($urandom_range(0, 99) < p);
        v1 = ($urandom_range(0, 99) < p);
        drive(1'b0, v0, $urandom, v1, $urandom);
        total++; if (valid_out !== m_valid) begin bad++; $display("FAIL rnd_valid e%0d c%0d: got %b want %b", e, c, valid_out, m_valid); end
        total++; if (data_out !== m_data) begin bad++; $display("FAIL rnd_data e%0d c%0d: got %h want %h", e, c, data_out, m_data); end
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf e%0d c%0d: got %b want %b", e, c, overflow, m_ovf); end
        total++; if (skew_err !== m_skew) begin bad++; $display("FAIL rnd_skew e%0d c%0d: got %b want %b", e, c, skew_err, m_skew); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_simultaneous();
    test_lane1_first();
    test_overflow();
    test_midstream_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_unstriping.md
Name: byte_unstriping

Overview:
Receive-side counterpart of the byte-striping block. It accepts two 32-bit lanes (lane 0, lane 1), each with its own valid, and reassembles them into a single 32-bit stream in strict alternating order: lane 0, lane 1, lane 0, and so on. It runs in the clk_2f domain. Each lane has a small FIFO that absorbs inter-lane skew, and the block flags overflow and lane misalignment.

Parameters:
DATA_W, 32, width of lane and output words
DEPTH, 4, per-lane FIFO depth in words (power of 2, >= 2)
SKEW_MAX, 3, max consecutive stalled cycles on the selected lane while the other lane is non-empty before skew_err sets

Ports:
clk_2f  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
lane0  in  DATA_W  lane 0 data word
valid_0  in  1  lane0 valid; one word is written per cycle in which it is high
lane1  in  DATA_W  lane 1 data word
valid_1  in  1  lane1 valid
data_out  out  DATA_W  reassembled data word (registered)
valid_out  out  1  data_out holds a new word this cycle (registered)
overflow  out  1  sticky: a lane word was dropped
skew_err  out  1  sticky: lane misalignment detected

Behaviour:
- Clocking and reset:
  - One clock, clk_2f. Reset is synchronous and active-high.
  - Reset values: data_out=0, valid_out=0, overflow=0, skew_err=0.
  - Reset also empties both FIFOs (read/write pointers and counts = 0), sets sel=0 and stall_cnt=0.
  - Reset asserted mid-stream discards all buffered words. The first word accepted after reset must come from lane 0.
- Upstream contract: each lane word is presented for exactly one clk_2f cycle with its valid high. A valid held high for N cycles writes N words.
- Push: at posedge, if valid_x=1, the lane word is written into FIFO x.
  - FIFO x full with no pop from x in the same cycle: word dropped, overflow<=1.
  - FIFO x full with a pop from x in the same cycle: push accepted, count unchanged.
- Selector state sel (1 bit, lane to read next), with two states:
  - READ_L0 (sel=0): if FIFO0 is non-empty, pop it, data_out<=head0, valid_out<=1, sel<=1. Otherwise valid_out<=0 and data_out holds its value.
  - READ_L1 (sel=1): same as READ_L0 using FIFO1; on pop, sel<=0.
  - A pop only ever takes from the selected lane. The other lane's words wait and are never reordered.
- Latency: a word pushed at posedge k, into an empty FIFO on the selected lane, appears on data_out/valid_out after posedge k+1. There is no same-cycle bypass, so minimum latency is 2 edges from the input being sampled to the output being visible.
- Throughput: at most 1 output word per cycle. Sustained valid on both lanes every cycle therefore overflows by design. Nominal traffic is one word per lane every 2 cycles.
- Skew detection: stall_cnt increments in each cycle where the selected FIFO is empty and the other FIFO is non-empty.
  - stall_cnt clears on any pop.
  - When stall_cnt reaches SKEW_MAX, skew_err<=1 (sticky). Reassembly keeps waiting and never skips a lane.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1, so count==DEPTH means full.
- Sticky flags clear only on reset.

Test Plan:
- Reset sequence: hold reset 2 cycles, then release -> all outputs 0; first valid_out appears only after a lane 0 word arrives.
- Nominal alternation: lane0=FFFFFFFF (cycle 0), lane1=EEEEEEEE (cycle 1), lane0=DDDDDDDD (cycle 2), lane1=CCCCCCCC (cycle 3) -> data_out sequence FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC, each with valid_out=1, first one 2 edges after input; overflow=0, skew_err=0.
- Simultaneous lanes: lane0=00000003 and lane1=00000004 in the same cycle, then idle -> data_out=00000003, then 00000004 on the next cycle; valid_out is high for exactly 2 cycles.
- Lane 1 first: lane1=AAAAAAAA alone for 3 cycles with no lane 0 words (SKEW_MAX=3) -> valid_out stays 0 and skew_err=1; then lane0=99999999 -> output 99999999 followed by the first AAAAAAAA.
- Overflow: 5 consecutive lane1 words 00000005..00000009 with lane 0 idle (DEPTH=4) -> overflow=1; after lane0=00000001 arrives, output is 00000001, 00000005, with 00000009 dropped.
- Mid-stream reset: 2 words buffered, then reset for 1 cycle -> FIFOs empty, valid_out=0, flags 0; the next lane0=BBBBBBBB is output first.
